// File: rtl/lsu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_mem_arbiter
//
// Responder for the per-thread LSU data-memory valid/ready channels. Up to
// NUM_CONSUMERS threads raise read or write requests; a round-robin scan
// started from rr_ptr picks one winner. The winner's request goes out on the
// single external memory channel. The completion (ready, plus read data for
// reads) is relayed back to that thread and held until the thread drops its
// valid. Only one transaction is in flight at a time. Every output comes
// straight from a flop.
//
// Configuration macro:
//   LSU_MEM_ARBITER_WRITE_EN  defined   -> read and write paths
//                             undefined -> read-only; write inputs ignored,
//                                          write outputs tied to 0
//
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   consumer_read_valid/_address     per-thread read request (flattened)
//   consumer_read_ready/_data        per-thread read completion + data
//   consumer_write_valid/_address/_data  per-thread write request
//   consumer_write_ready             per-thread write completion
//   mem_read_valid/_address, mem_read_ready/_data   external read channel
//   mem_write_valid/_address/_data, mem_write_ready external write channel
// ---------------------------------------------------------------------------
module lsu_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        RELAY      = 2'd2
`ifdef LSU_MEM_ARBITER_WRITE_EN
        ,
        WRITE_WAIT = 2'd3
`endif
    } state_e;

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                   grant_q, grant_d;
    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
    logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;
    logic [NUM_CONSUMERS-1:0]           any_req;
    logic                               found;

`ifdef LSU_MEM_ARBITER_WRITE_EN
    // op_read_q tells RELAY which valid to watch for the handshake close.
    logic                               op_read_q, op_read_d;
    logic                               mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;

    assign any_req = consumer_read_valid | consumer_write_valid;
`else
    // The write side is compiled out. These inputs are folded here only so
    // that their being unconnected is deliberate and visible.
    logic unused_write_inputs;
    assign unused_write_inputs = ^{consumer_write_valid, consumer_write_address,
                                   consumer_write_data, mem_write_ready};
    assign any_req = consumer_read_valid;
`endif

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every target a
        // default first, so no path leaves a signal unassigned (no latches).
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        grant_d            = grant_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        read_ready_d       = read_ready_q;
        read_data_d        = read_data_q;
        found              = 1'b0;
`ifdef LSU_MEM_ARBITER_WRITE_EN
        op_read_d           = op_read_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        write_ready_d       = write_ready_q;
`endif

        case (state_q)
            IDLE: begin
                // The scan starts at rr_ptr and wraps. The thread just served
                // moves to the back of the line.
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    int idx;
                    idx = (int'(rr_ptr_q) + k) % NUM_CONSUMERS;
                    if (!found && any_req[idx]) begin
                        found    = 1'b1;
                        grant_d  = IDX_W'(idx);
                        rr_ptr_d = IDX_W'((idx + 1) % NUM_CONSUMERS);
                        // When a thread has both a read and a write pending,
                        // the read goes first and the write waits for a later
                        // grant.
                        if (consumer_read_valid[idx]) begin
                            mem_read_valid_d   = 1'b1;
                            mem_read_address_d = consumer_read_address[idx*ADDR_BITS +: ADDR_BITS];
                            state_d            = READ_WAIT;
`ifdef LSU_MEM_ARBITER_WRITE_EN
                            op_read_d          = 1'b1;
`endif
                        end
`ifdef LSU_MEM_ARBITER_WRITE_EN
                        else begin
                            mem_write_valid_d   = 1'b1;
                            mem_write_address_d = consumer_write_address[idx*ADDR_BITS +: ADDR_BITS];
                            mem_write_data_d    = consumer_write_data[idx*DATA_BITS +: DATA_BITS];
                            state_d             = WRITE_WAIT;
                            op_read_d           = 1'b0;
                        end
`endif
                    end
                end
            end

            READ_WAIT: begin
                // The external transaction always completes. A consumer that
                // drops valid here does not abort it.
                if (mem_read_ready) begin
                    mem_read_valid_d = 1'b0;
                    read_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
                    read_ready_d[grant_q] = 1'b1;
                    state_d = RELAY;
                end
            end

`ifdef LSU_MEM_ARBITER_WRITE_EN
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d      = 1'b0;
                    write_ready_d[grant_q] = 1'b1;
                    state_d                = RELAY;
                end
            end
`endif

            RELAY: begin
`ifdef LSU_MEM_ARBITER_WRITE_EN
                if (op_read_q) begin
                    if (!consumer_read_valid[grant_q]) begin
                        read_ready_d[grant_q] = 1'b0;
                        state_d               = IDLE;
                    end
                end else begin
                    if (!consumer_write_valid[grant_q]) begin
                        write_ready_d[grant_q] = 1'b0;
                        state_d                = IDLE;
                    end
                end
`else
                if (!consumer_read_valid[grant_q]) begin
                    read_ready_d[grant_q] = 1'b0;
                    state_d               = IDLE;
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            rr_ptr_q           <= '0;
            grant_q            <= '0;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            read_ready_q       <= '0;
            // NOTE: the read-data lanes are outputs that must read as zero
            // after reset. That is why this storage gets a reset, which is
            // not usually wanted for data arrays.
            read_data_q        <= '0;
`ifdef LSU_MEM_ARBITER_WRITE_EN
            op_read_q           <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            write_ready_q       <= '0;
`endif
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            grant_q            <= grant_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            read_ready_q       <= read_ready_d;
            read_data_q        <= read_data_d;
`ifdef LSU_MEM_ARBITER_WRITE_EN
            op_read_q           <= op_read_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            write_ready_q       <= write_ready_d;
`endif
        end
    end

    assign consumer_read_ready = read_ready_q;
    assign consumer_read_data  = read_data_q;
    assign mem_read_valid      = mem_read_valid_q;
    assign mem_read_address    = mem_read_address_q;

`ifdef LSU_MEM_ARBITER_WRITE_EN
    assign consumer_write_ready = write_ready_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
`else
    assign consumer_write_ready = '0;
    assign mem_write_valid      = 1'b0;
    assign mem_write_address    = '0;
    assign mem_write_data       = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_arbiter
//
// Directed bench for lsu_mem_arbiter with the default parameters (8/8/16).
// Read requests push {thread, address, data} onto a scoreboard in the order
// the round-robin arbiter should grant them. The memory side answers every
// read with addr ^ 8'h76. Each grant on the memory channel pops one entry,
// and that entry is compared with the address and with the consumer lane
// that completes. Write checks follow the LSU_MEM_ARBITER_WRITE_EN build
// setting.
// ---------------------------------------------------------------------------
module tb_lsu_mem_arbiter;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int N  = 16;

    logic              clk;
    logic              reset;
    logic [N-1:0]      consumer_read_valid;
    logic [N*AB-1:0]   consumer_read_address;
    logic [N-1:0]      consumer_read_ready;
    logic [N*DB-1:0]   consumer_read_data;
    logic [N-1:0]      consumer_write_valid;
    logic [N*AB-1:0]   consumer_write_address;
    logic [N*DB-1:0]   consumer_write_data;
    logic [N-1:0]      consumer_write_ready;
    logic              mem_read_valid;
    logic [AB-1:0]     mem_read_address;
    logic              mem_read_ready;
    logic [DB-1:0]     mem_read_data;
    logic              mem_write_valid;
    logic [AB-1:0]     mem_write_address;
    logic [DB-1:0]     mem_write_data;
    logic              mem_write_ready;

    lsu_mem_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         thread;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [7:0] mem_model(input logic [7:0] a);
        return a ^ 8'h76;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req_read(input int t, input logic [7:0] a);
        consumer_read_address[t*AB +: AB] = a;
        consumer_read_valid[t]            = 1'b1;
        sb.push_back('{t, a, mem_model(a)});
    endtask

    task automatic wait_mem_read();
        int cyc;
        cyc = 0;
        while (!mem_read_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!mem_read_valid) check("mem_read_valid_timeout", mem_read_valid, 1);
    endtask

    // Serves one read grant from the scoreboard. The memory inserts 'waits'
    // stall cycles, and the task then closes the consumer handshake.
    task automatic do_read_txn(input int waits, input string tag);
        exp_t e;
        wait_mem_read();
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_mem_addr"}, mem_read_address, e.addr);
        check({tag, "_no_write_valid"}, mem_write_valid, 0);
        check({tag, "_ready_idle"}, consumer_read_ready, 0);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            check({tag, "_valid_held"}, mem_read_valid, 1);
            check({tag, "_addr_held"}, mem_read_address, e.addr);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = e.data;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        check({tag, "_mem_valid_low"}, mem_read_valid, 0);
        check({tag, "_ready_onehot"}, consumer_read_ready, 16'(1) << e.thread);
        check({tag, "_lane_data"}, consumer_read_data[e.thread*DB +: DB], e.data);
        check({tag, "_no_write_ready"}, consumer_write_ready, 0);
        @(negedge clk);
        check({tag, "_ready_hold"}, consumer_read_ready, 16'(1) << e.thread);
        consumer_read_valid[e.thread] = 1'b0;
        @(negedge clk);
        check({tag, "_ready_clear"}, consumer_read_ready, 0);
    endtask

`ifdef LSU_MEM_ARBITER_WRITE_EN
    task automatic do_write_txn(input int t, input logic [7:0] a, input logic [7:0] d,
                                input string tag);
        int cyc;
        cyc = 0;
        while (!mem_write_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_mem_write_valid"}, mem_write_valid, 1);
        check({tag, "_mem_write_addr"}, mem_write_address, a);
        check({tag, "_mem_write_data"}, mem_write_data, d);
        check({tag, "_no_read_valid"}, mem_read_valid, 0);
        @(negedge clk);
        check({tag, "_write_held"}, {mem_write_valid, mem_write_address, mem_write_data},
              {1'b1, a, d});
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        check({tag, "_mem_write_low"}, mem_write_valid, 0);
        check({tag, "_write_ready"}, consumer_write_ready, 16'(1) << t);
        check({tag, "_no_read_ready"}, consumer_read_ready, 0);
        @(negedge clk);
        check({tag, "_write_ready_hold"}, consumer_write_ready, 16'(1) << t);
        consumer_write_valid[t] = 1'b0;
        @(negedge clk);
        check({tag, "_write_ready_clear"}, consumer_write_ready, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b0;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_read_valid", mem_read_valid, 0);
        check("rst_mem_write_valid", mem_write_valid, 0);
        check("rst_read_ready", consumer_read_ready, 0);
        check("rst_write_ready", consumer_write_ready, 0);
        check("rst_read_data", consumer_read_data, 0);
        check("rst_mem_addrs", {mem_read_address, mem_write_address, mem_write_data}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single read: thread 3 reads 0x2A with two memory wait cycles
        req_read(3, 8'h2A);
        @(negedge clk);
        check("single_grant_latency", mem_read_valid, 1);
        do_read_txn(2, "single");

        // Round robin from reset: 0, 5, 15, then the pointer wraps to 0
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_read(0, 8'h01);
        req_read(5, 8'h05);
        req_read(15, 8'h0F);
        do_read_txn(0, "rr_a");
        do_read_txn(0, "rr_b");
        check("lane0_kept", consumer_read_data[0*DB +: DB], mem_model(8'h01));
        do_read_txn(0, "rr_c");
        req_read(0, 8'h20);
        req_read(15, 8'h1F);
        do_read_txn(0, "wrap_a");
        do_read_txn(0, "wrap_b");

        // Fairness: thread 9 waits while thread 2 is served, and thread 2
        // re-requests as soon as it is released
        req_read(2, 8'h22);
        @(negedge clk);
        req_read(9, 8'h99);
        do_read_txn(1, "fair_a");
        req_read(2, 8'h23);
        do_read_txn(0, "fair_b");
        do_read_txn(0, "fair_c");

        // Write: thread 7 writes 0xA1 to 0x10
        consumer_write_address[7*AB +: AB] = 8'h10;
        consumer_write_data[7*DB +: DB]    = 8'hA1;
        consumer_write_valid[7]            = 1'b1;
`ifdef LSU_MEM_ARBITER_WRITE_EN
        do_write_txn(7, 8'h10, 8'hA1, "write");
`else
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ro_write_valid", mem_write_valid, 0);
            check("ro_write_ready", consumer_write_ready, 0);
        end
        consumer_write_valid[7] = 1'b0;
`endif

        // Read/write conflict on thread 4: the read is served first
        consumer_write_address[4*AB +: AB] = 8'h45;
        consumer_write_data[4*DB +: DB]    = 8'h5A;
        consumer_write_valid[4]            = 1'b1;
        req_read(4, 8'h44);
        do_read_txn(0, "conflict_rd");
`ifdef LSU_MEM_ARBITER_WRITE_EN
        do_write_txn(4, 8'h45, 8'h5A, "conflict_wr");
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ro_conflict_idle", {mem_read_valid, mem_write_valid}, 0);
            check("ro_conflict_wready", consumer_write_ready, 0);
        end
        consumer_write_valid[4] = 1'b0;
`endif

        // Reset in the middle of READ_WAIT
        req_read(6, 8'h66);
        wait_mem_read();
        @(negedge clk);
        check("midrst_pre_valid", mem_read_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_mem_read_valid", mem_read_valid, 0);
        check("midrst_ready", {consumer_read_ready, consumer_write_ready}, 0);
        check("midrst_read_data", consumer_read_data, 0);
        check("midrst_mem_write_valid", mem_write_valid, 0);
        void'(sb.pop_front());
        consumer_read_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        req_read(0, 8'h70);
        @(negedge clk);
        check("postrst_grant_latency", mem_read_valid, 1);
        do_read_txn(0, "postrst");

        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
